// File: rtl/approx_error_monitor.sv
// rtl/approx_error_monitor.sv - error statistics accumulator for the approximate multiplier
// Counts samples/mismatches, sums |approx-exact| with saturation, tracks the maximum distance.
module approx_error_monitor #(
    parameter int PW        = 13,
    parameter int CNT_W     = 16,
    parameter int SUM_W     = 29,
    parameter int N_SAMPLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    approx_prod,
    input  logic [PW-1:0]    exact_prod,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_ed,
    output logic [PW-1:0]    max_ed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic last_sample;
    logic in_ready_next;
    logic done_next;

    logic [PW:0]    diff;
    logic [PW:0]    diff_neg;
    logic [PW-1:0]  ed;
    logic [SUM_W:0] sum_wide;
    logic [SUM_W-1:0] sum_sat;

    // in_ready is a registered copy of (state == RUN), so it gates accepts directly.
    assign accept      = in_valid & in_ready;
    assign last_sample = (sample_cnt == CNT_W'(N_SAMPLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= in_ready_next;
            busy     <= in_ready_next;
            done     <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (!start && accept && last_sample) state_next = DONE;
            end
            DONE: begin
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_next = (state_next == RUN);
        done_next     = (state_next == DONE);
    end

    // Zero-extended operands make the PW+1-bit difference a correct signed value.
    always_comb begin
        diff     = {1'b0, approx_prod} - {1'b0, exact_prod};
        diff_neg = -diff;
        ed       = diff[PW] ? diff_neg[PW-1:0] : diff[PW-1:0];
        sum_wide = {1'b0, sum_ed} + {{(SUM_W + 1 - PW){1'b0}}, ed};
        sum_sat  = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
    end

    // start clears from any state and takes priority over a coincident sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (start) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (ed != '0) err_cnt <= err_cnt + CNT_W'(1);
            sum_ed <= sum_sat;
            if (ed > max_ed) max_ed <= ed;
        end
    end

endmodule

// File: tb/tb_approx_error_monitor.sv
// tb/tb_approx_error_monitor.sv - scoreboard bench for approx_error_monitor
// Driver pushes expected snapshots from a run-list model; monitor pops one per clock and compares.
module tb_approx_error_monitor;

    localparam int PW    = 13;
    localparam int CNT_W = 16;
    localparam int SUM_W = 14;
    localparam int N     = 4;
    localparam int SMAX  = (1 << SUM_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PW-1:0]    approx_prod = '0;
    logic [PW-1:0]    exact_prod = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [SUM_W-1:0] sum_ed;
    logic [PW-1:0]    max_ed;

    approx_error_monitor #(
        .PW(PW), .CNT_W(CNT_W), .SUM_W(SUM_W), .N_SAMPLES(N)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .approx_prod(approx_prod), .exact_prod(exact_prod), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             in_ready;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] ec;
        logic [SUM_W-1:0] sum;
        logic [PW-1:0]    mx;
    } snap_t;

    snap_t exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    // Model: 0 idle, 1 running, 2 finished; the run is just the list of distances seen.
    int    m_state = 0;
    int    m_eds[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        int tot = 0;
        int errs = 0;
        int mx = 0;
        foreach (m_eds[i]) begin
            tot += m_eds[i];
            if (m_eds[i] != 0) errs++;
            if (m_eds[i] > mx) mx = m_eds[i];
        end
        s.in_ready = (m_state == 1);
        s.busy     = (m_state == 1);
        s.done     = (m_state == 2);
        s.sc       = CNT_W'(m_eds.size());
        s.ec       = CNT_W'(errs);
        s.sum      = SUM_W'((tot > SMAX) ? SMAX : tot);
        s.mx       = PW'(mx);
        return s;
    endfunction

    task automatic model_update(input bit st, input bit iv, input int ap, input int ex);
        if (st) begin
            m_eds.delete();
            m_state = 1;
        end else if (m_state == 1 && iv) begin
            m_eds.push_back((ap > ex) ? ap - ex : ex - ap);
            if (m_eds.size() == N) m_state = 2;
        end
    endtask

    task automatic step(input bit r, input bit st, input bit iv, input int ap, input int ex);
        @(negedge clk);
        rst         = r;
        start       = st;
        in_valid    = iv;
        approx_prod = PW'(ap);
        exact_prod  = PW'(ex);
        if (r) begin
            m_state = 0;
            m_eds.delete();
            #1;
            check("async_rst_in_ready", 32'(in_ready), 0);
            check("async_rst_busy", 32'(busy), 0);
            check("async_rst_done", 32'(done), 0);
            check("async_rst_sample_cnt", 32'(sample_cnt), 0);
            check("async_rst_err_cnt", 32'(err_cnt), 0);
            check("async_rst_sum_ed", 32'(sum_ed), 0);
            check("async_rst_max_ed", 32'(max_ed), 0);
        end else begin
            model_update(st, iv, ap, ex);
        end
        exp_q.push_back(model_snap());
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("in_ready", 32'(in_ready), 32'(e.in_ready));
                check("busy", 32'(busy), 32'(e.busy));
                check("done", 32'(done), 32'(e.done));
                check("sample_cnt", 32'(sample_cnt), 32'(e.sc));
                check("err_cnt", 32'(err_cnt), 32'(e.ec));
                check("sum_ed", 32'(sum_ed), 32'(e.sum));
                check("max_ed", 32'(max_ed), 32'(e.mx));
            end
        end
    end

    initial begin : driver
        int ap;
        int ex;
        bit r;
        bit st;
        bit iv;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 7, 3);
        step(0, 0, 0, 0, 0);

        // Reset mid-run with mismatching samples
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 10 + i, 200 + i);
        step(1, 0, 1, 5, 9);
        step(1, 0, 1, 5, 9);
        step(0, 0, 0, 0, 0);

        // Exact run, then in_valid in DONE ignored
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1521, 1521);
        step(0, 0, 1, 0, 100);
        step(0, 0, 0, 0, 0);

        // Signed error, plus a stall pattern
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 100, 96);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 55, 1);
        step(0, 0, 1, 90, 96);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 3969, 3969);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 4096);
        step(0, 0, 1, 8191, 0);
        step(0, 0, 0, 0, 0);

        // Restart in DONE, then start colliding with a sample in RUN
        step(0, 1, 1, 0, 8000);
        step(0, 0, 1, 20, 10);
        step(0, 1, 1, 0, 8000);
        step(0, 0, 1, 6, 6);
        step(0, 0, 0, 0, 0);

        // Saturation and tie on max
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 8191);
        step(0, 0, 1, 8191, 0);
        step(0, 0, 1, 0, 4095);
        step(0, 0, 1, 0, 8191);
        step(0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 79) == 0);
            st = ($urandom_range(0, 14) == 0);
            iv = ($urandom_range(0, 2) != 0);
            ap = $urandom_range(0, 8191);
            ex = ($urandom_range(0, 3) == 0) ? ap : $urandom_range(0, 8191);
            if ($urandom_range(0, 3) == 0) ex = (ap + $urandom_range(0, 16)) % 8192;
            step(r, st, iv, ap, ex);
        end
        step(0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
